ibex_rvfi_trace_buffer: RTL

//  Consumes the RVFI retirement port of the tracing Ibex top level. Each retired

---
 rtl/ibex_rvfi_trace_buffer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/ibex_rvfi_trace_buffer.sv
// RVFI retirement trace buffer: captures retired instructions into a record FIFO
// and streams each record as four 32-bit words over a valid/ready interface.
module ibex_rvfi_trace_buffer #(
  parameter  int unsigned Depth  = 8,
  localparam int unsigned LevelW = $clog2(Depth) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              trace_en_i,
  input  logic              rvfi_valid,
  input  logic [63:0]       rvfi_order,
  input  logic [31:0]       rvfi_insn,
  input  logic              rvfi_trap,
  input  logic              rvfi_halt,
  input  logic              rvfi_intr,
  input  logic [1:0]        rvfi_mode,
  input  logic [4:0]        rvfi_rd_addr,
  input  logic [31:0]       rvfi_rd_wdata,
  input  logic [31:0]       rvfi_pc_rdata,
  output logic              trace_valid_o,
  input  logic              trace_ready_i,
  output logic [31:0]       trace_data_o,
  output logic              trace_last_o,
  output logic [LevelW-1:0] fifo_level_o,
  output logic              overflow_o,
  input  logic              overflow_clr_i
);

  localparam int unsigned AW = $clog2(Depth);

  logic [127:0]       mem_q [Depth];
  logic [127:0]       mem_d [Depth];
  logic [AW-1:0]      wptr_q, wptr_d;
  logic [AW-1:0]      rptr_q, rptr_d;
  logic [LevelW-1:0]  level_q, level_d;
  logic [1:0]         widx_q, widx_d;
  logic [7:0]         drop_cnt_q, drop_cnt_d;
  logic               overflow_q, overflow_d;

  logic               out_valid;
  logic               fire;
  logic               pop;
  logic               capture;
  logic               push;
  logic               drop;
  logic [31:0]        header;
  logic [127:0]       head_entry;
  logic [31:0]        head_word;
  logic               unused_order;

  assign unused_order = ^rvfi_order[63:6];

  // Handshake decode; a pop frees a slot in the same cycle so a full FIFO can still accept
  always_comb begin
    out_valid = (level_q != '0);
    fire      = out_valid & trace_ready_i;
    pop       = fire & (widx_q == 2'd3);
    capture   = rvfi_valid & trace_en_i;
    push      = capture & ((level_q < LevelW'(Depth)) | pop);
    drop      = capture & ~push;
    header    = {8'hA5, rvfi_trap, rvfi_intr, rvfi_halt, rvfi_mode, rvfi_rd_addr,
                 drop_cnt_q, rvfi_order[5:0]};
  end

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wptr_q] = {header, rvfi_pc_rdata, rvfi_insn, rvfi_rd_wdata};
    end else begin
      mem_d = mem_q;
    end

    wptr_d = push ? (wptr_q + AW'(1)) : wptr_q;
    rptr_d = pop  ? (rptr_q + AW'(1)) : rptr_q;

    case ({push, pop})
      2'b10:   level_d = level_q + LevelW'(1);
      2'b01:   level_d = level_q - LevelW'(1);
      default: level_d = level_q;
    endcase

    // Two-bit index wraps 3 -> 0 exactly when the record pops
    widx_d = fire ? (widx_q + 2'd1) : widx_q;
  end

  // Drop counter snapshots into each accepted header, then restarts
  always_comb begin
    if (push) begin
      drop_cnt_d = 8'd0;
    end else if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end

    if (overflow_clr_i) begin
      overflow_d = 1'b0;
    end else if (drop) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_comb begin
    head_entry = mem_q[rptr_q];
    case (widx_q)
      2'd0:    head_word = head_entry[127:96];
      2'd1:    head_word = head_entry[95:64];
      2'd2:    head_word = head_entry[63:32];
      2'd3:    head_word = head_entry[31:0];
      default: head_word = 32'd0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= 128'd0;
      end
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      widx_q     <= 2'd0;
      drop_cnt_q <= 8'd0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      widx_q     <= widx_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage contents are hidden while empty so idle outputs read as zero
  assign trace_valid_o = out_valid;
  assign trace_data_o  = out_valid ? head_word : 32'd0;
  assign trace_last_o  = out_valid & (widx_q == 2'd3);
  assign fifo_level_o  = level_q;
  assign overflow_o    = overflow_q;

endmodule
